int_ctrl: RTL
=============

Name: int_ctrl

Overview:
- Interrupt controller that drives the 8-bit one-hot `irq` vector consumed by the fetch stage. The fetch stage redirects the PC to a fixed vector on that vector.
- Latches and masks up to 8 peripheral requests (bit0 timer, bit1 uart, bit2 bt, bits 7:3 spare) and arbitrates them by fixed priority.
- Issues one request at a time, saves the return PC (EPC), and blocks further requests until the handler signals return.
- Configured by the core through a small register port.

Parameters:
- CPU_WIDTH, 16, width of PC, branch target and register data.
- NUM_SRC, 8, number of interrupt sources; fixed to 8 to match the irq vector width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- src_irq  in  8  raw peripheral requests, synchronous to clk
- pc  in  CPU_WIDTH  current fetch PC
- jump_flag  in  1  branch/jump redirect active this cycle
- branch_pc  in  CPU_WIDTH  redirect target
- inst_valid  in  1  fetched instruction non-zero; 0 means fetch is stalled
- iret  in  1  single-cycle pulse: handler return executed
- cfg_we  in  1  register write strobe
- cfg_addr  in  2  register select
- cfg_wdata  in  CPU_WIDTH  write data
- cfg_rdata  out  CPU_WIDTH  read data, combinational on cfg_addr
- irq  out  8  one-hot interrupt request to the fetch stage
- epc  out  CPU_WIDTH  saved return PC
- in_service  out  1  a handler is active

Behaviour:
- Reset values:
  - irq = 0, epc = 0, in_service = 0.
  - pending = 0, mask = 0, gie = 0.
  - State = IDLE, src_d = 0.
- Edge detect (default build): `rise = src_irq & ~src_d`, where `src_d` is src_irq registered.
- pending[i] is set on rise[i] and is cleared by:
  - a W1C write, or
  - the ISSUE state for the granted bit.
- If set and clear fall in the same cycle, set wins.
- Register map:
  - addr 0 MASK: bits 7:0 R/W; 1 = source enabled.
  - addr 1 PEND: bits 7:0 R; a write clears the bits written as 1.
  - addr 2 CTRL: bit0 = gie R/W; bit1 = in_service, read-only.
  - addr 3 EPC: read-only.
  - Unused read bits return 0.
- Request: `req = pending & mask`. Grant = lowest set index of req (bit0 has highest priority).
- FSM:
  - IDLE:
    - Stays in IDLE while any of these hold: gie = 0, req = 0, or inst_valid = 0 with jump_flag = 0 (stalled fetch).
    - Otherwise registers `irq <= onehot(grant)` and `epc <= jump_flag ? branch_pc : pc + 1` (wraps modulo 2^CPU_WIDTH), clears pending[grant], and moves to ISSUE.
  - ISSUE: irq is held for exactly one cycle (the fetch stage loads the vector in this cycle). Then irq <= 0, in_service <= 1, and the FSM moves to SERVICE.
  - SERVICE: when iret = 1, in_service <= 0 and the FSM moves to IDLE. A new request may be issued no earlier than the cycle after returning to IDLE.
- Boundary conditions:
  - iret in IDLE or ISSUE is ignored.
  - Edges arriving during ISSUE or SERVICE are latched in pending and served afterwards.
  - Clearing a mask bit does not cancel an ISSUE already in progress.
  - An edge on the granted source during its own ISSUE cycle re-sets its pending bit.
  - gie = 0 during SERVICE does not abort the handler; it only blocks the next issue.
  - Reset mid-operation returns everything to reset values immediately.
- Latency: source edge at cycle N → pending set at N+1 → irq high at N+2, given IDLE, gie = 1, unmasked, fetch not stalled.

Optional Feature:
- Macro: INTC_LEVEL_EN.
- Defined: sources are level-sensitive. pending[i] follows src_irq[i] each cycle, W1C has no lasting effect while the source stays high, the granted bit is not cleared by ISSUE, and the edge-detect register is removed. After iret, a source still high re-triggers.
- Undefined: edge-triggered as described above.

Decomposition:
- Shared package holds:
  - FSM state encodings IDLE = 2'd0, ISSUE = 2'd1, SERVICE = 2'd2.
  - Register addresses MASK / PEND / CTRL / EPC.
  - Source bit indices (timer = 0, uart = 1, bt = 2).
- Sub-module `int_prio_enc`: 8-bit request in, one-hot grant plus a valid flag out, lowest index wins. Purely combinational.
- Everything else lives in int_ctrl.

Test Plan:
- Reset, then write MASK = 0x01 and CTRL = 0x1, pc = 0x0040, inst_valid = 1; pulse src_irq[0] at cycle N → irq = 0x01 only at N+2, epc = 0x0041, in_service = 1 at N+3.
- Assert src_irq[1] and src_irq[2] rising in the same cycle with MASK = 0x06 → irq = 0x02 first. After an iret pulse, irq = 0x04 is issued, and PEND reads 0x00 after both issues.
- jump_flag = 1 with branch_pc = 0x0123 in the issue cycle → epc = 0x0123. With pc = 0xFFFF and no jump → epc = 0x0000 (wrap).
- With gie = 0, pulse src_irq[0] → irq stays 0 and PEND = 0x01. Write PEND = 0x01 → PEND = 0x00. Set gie = 1 → no irq is issued.
- During SERVICE, pulse src_irq[0] → no irq until the iret pulse, then irq = 0x01 two cycles later. Deassert rst_n mid-SERVICE → all outputs 0 immediately.
- With INTC_LEVEL_EN defined, hold src_irq[1] high with MASK = 0x02 → irq = 0x02. After iret, irq = 0x02 is re-issued. Dropping src_irq[1] stops further issues.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
// State encoding, register map and source bit assignments.
package int_ctrl_pkg;

  localparam int CPU_WIDTH = 16;
  localparam int NUM_SRC   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_EPC  = 2'd3;

  localparam int SRC_TIMER = 0;
  localparam int SRC_UART  = 1;
  localparam int SRC_BT    = 2;

endpackage

// File: rtl/int_ctrl_if.sv
// Core-side configuration register port of the interrupt controller.
// Writes take effect on the next clk edge; reads are combinational on cfg_addr.
interface int_ctrl_if
  import int_ctrl_pkg::*;
();

  logic                 cfg_we;
  logic [1:0]           cfg_addr;
  logic [CPU_WIDTH-1:0] cfg_wdata;
  logic [CPU_WIDTH-1:0] cfg_rdata;

  modport master (output cfg_we, output cfg_addr, output cfg_wdata, input cfg_rdata);
  modport slave  (input cfg_we, input cfg_addr, input cfg_wdata, output cfg_rdata);

endinterface

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: one-hot grant of the lowest set request bit, plus valid.
// Latency: purely combinational; no backpressure.
module int_prio_enc
  import int_ctrl_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] grant,
  output logic               vld
);

  // Two's-complement trick isolates the lowest set bit.
  assign grant = req & (~req + NUM_SRC'(1));
  assign vld   = |req;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: latch/mask 8 sources, issue one-hot irq, save EPC. Optional INTC_LEVEL_EN.
// Latency: source edge at N -> irq at N+2; blocks new issues until iret (no other backpressure).
module int_ctrl
  import int_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   src_irq,
  input  logic [CPU_WIDTH-1:0] pc,
  input  logic                 jump_flag,
  input  logic [CPU_WIDTH-1:0] branch_pc,
  input  logic                 inst_valid,
  input  logic                 iret,
  int_ctrl_if.slave            cfg,
  output logic [NUM_SRC-1:0]   irq,
  output logic [CPU_WIDTH-1:0] epc,
  output logic                 in_service
);

  state_t               state, state_nxt;
  logic [NUM_SRC-1:0]   pending, mask, req, grant, w1c_clr;
  logic                 gie, grant_vld;
  logic                 issue_go, enter_svc, leave_svc;
  logic                 unused_wdata;

  assign req          = pending & mask;
  assign w1c_clr      = (cfg.cfg_we && cfg.cfg_addr == ADDR_PEND) ? cfg.cfg_wdata[NUM_SRC-1:0] : '0;
  assign unused_wdata = ^cfg.cfg_wdata[CPU_WIDTH-1:NUM_SRC];

  int_prio_enc u_prio (
    .req   (req),
    .grant (grant),
    .vld   (grant_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue_go)  state_nxt = ISSUE;
      ISSUE:                  state_nxt = SERVICE;
      SERVICE: if (leave_svc) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // A stalled fetch (no instruction, no redirect) has no valid return PC.
  always_comb begin
    issue_go  = 1'b0;
    enter_svc = 1'b0;
    leave_svc = 1'b0;
    case (state)
      IDLE:    issue_go  = gie && grant_vld && (inst_valid || jump_flag);
      ISSUE:   enter_svc = 1'b1;
      SERVICE: leave_svc = iret;
      default: ;
    endcase
  end

`ifdef INTC_LEVEL_EN
  logic unused_level;
  assign unused_level = ^w1c_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= src_irq;
  end
`else
  logic [NUM_SRC-1:0] src_d;

  // New rises win over any clear landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_d   <= '0;
      pending <= '0;
    end else begin
      src_d   <= src_irq;
      pending <= (pending & ~w1c_clr & ~(issue_go ? grant : '0)) | (src_irq & ~src_d);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask       <= '0;
      gie        <= 1'b0;
      irq        <= '0;
      epc        <= '0;
      in_service <= 1'b0;
    end else begin
      if (cfg.cfg_we && cfg.cfg_addr == ADDR_MASK) mask <= cfg.cfg_wdata[NUM_SRC-1:0];
      if (cfg.cfg_we && cfg.cfg_addr == ADDR_CTRL) gie  <= cfg.cfg_wdata[0];
      if (issue_go) begin
        irq <= grant;
        epc <= jump_flag ? branch_pc : pc + CPU_WIDTH'(1);
      end
      if (enter_svc) begin
        irq        <= '0;
        in_service <= 1'b1;
      end
      if (leave_svc) in_service <= 1'b0;
    end
  end

  always_comb begin
    cfg.cfg_rdata = '0;
    case (cfg.cfg_addr)
      ADDR_MASK: cfg.cfg_rdata = CPU_WIDTH'(mask);
      ADDR_PEND: cfg.cfg_rdata = CPU_WIDTH'(pending);
      ADDR_CTRL: cfg.cfg_rdata = CPU_WIDTH'({in_service, gie});
      ADDR_EPC:  cfg.cfg_rdata = epc;
      default:   cfg.cfg_rdata = '0;
    endcase
  end

endmodule
